// File: rtl/fram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fram_arbiter_if
// Description : Bus bundle between the frame-memory arbiter, its two
//               requesters (fe, de) and the frame-memory read port.
//               slave  - arbiter side (takes requests, drives grants/data).
//               master - requester / memory side.
// Signals     : fe_req, fe_address[15:0], fe_grant, fe_valid, fe_data[7:0]
//               de_req, de_address[19:0], de_grant, de_valid, de_data[7:0]
//               fram_address[20:0], fram_datain[7:0], busy
// Revision    : 1.0 - initial release
// ============================================================================
interface fram_arbiter_if;
  logic        fe_req;
  logic [15:0] fe_address;
  logic        fe_grant;
  logic        fe_valid;
  logic [7:0]  fe_data;

  logic        de_req;
  logic [19:0] de_address;
  logic        de_grant;
  logic        de_valid;
  logic [7:0]  de_data;

  logic [20:0] fram_address;
  logic [7:0]  fram_datain;
  logic        busy;

  modport slave (
    input  fe_req, fe_address, de_req, de_address, fram_datain,
    output fe_grant, fe_valid, fe_data, de_grant, de_valid, de_data,
           fram_address, busy
  );

  modport master (
    output fe_req, fe_address, de_req, de_address, fram_datain,
    input  fe_grant, fe_valid, fe_data, de_grant, de_valid, de_data,
           fram_address, busy
  );
endinterface
`default_nettype wire

// File: rtl/fram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fram_arbiter
// Description : Round-robin arbiter for the single 8-bit frame-memory read
//               port, shared by the feature-extraction core (fe) and the
//               decoder core (de). Bounded bursts, per-requester base
//               address, tagged valid pipeline for returning read data.
// Ports       : clk, reset (async, active high)
//               bus  (fram_arbiter_if.slave) - requests, grants, read data,
//                    registered fram_address, fram_datain, busy
//               FRAM_ARB_STATS_EN only: stats_clr in, fe_cnt/de_cnt/
//                    stall_cnt [15:0] out (saturating counters)
// Options     : `define FRAM_ARB_STATS_EN to add the statistics counters.
// Timing      : RD_LAT counts from the grant cycle G and includes the
//               fram_address register: the address is on the bus from G+1,
//               fram_datain is captured at the end of cycle G+RD_LAT-1 and
//               data/valid are visible in cycle G+RD_LAT.
// Revision    : 1.0 - initial release
// ============================================================================
module fram_arbiter #(
  parameter int          RD_LAT    = 2,
  parameter int          MAX_BURST = 8,
  parameter logic [20:0] FE_BASE   = 21'h100000,
  parameter logic [20:0] DE_BASE   = 21'h000000
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FRAM_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] fe_cnt,
  output logic [15:0] de_cnt,
  output logic [15:0] stall_cnt,
`endif
  fram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FE_OWN = 2'd1,
    DE_OWN = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;          // 0: fe wins a tie, 1: de wins
  logic [7:0]        burst_q, burst_d;
  logic [20:0]       addr_q, addr_d;
  logic              fe_gnt, de_gnt;
  logic [RD_LAT-1:0] iss_q, own_q;        // own: 0 = fe, 1 = de
  logic [7:0]        fe_data_q, de_data_q;

  // Stage 0 of each chain is this cycle's grant; stage k is iss_q[k-1].
  // The top stage drives the valids, the one below it gates data capture.
  logic [RD_LAT:0]   iss_chain, own_chain;
  assign iss_chain = {iss_q, fe_gnt | de_gnt};
  assign own_chain = {own_q, de_gnt};

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    fe_gnt  = 1'b0;
    de_gnt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fe_req && (!bus.de_req || !rr_q)) begin
          state_d = FE_OWN;
        end else if (bus.de_req) begin
          state_d = DE_OWN;
        end
      end
      FE_OWN: begin
        // Release and forced handover share one path: no grant this cycle.
        if (!bus.fe_req || (burst_q == BURST_LIMIT && bus.de_req)) begin
          state_d = bus.de_req ? DE_OWN : IDLE;
          burst_d = 8'd0;
          rr_d    = 1'b1;
        end else begin
          fe_gnt = 1'b1;
          addr_d = FE_BASE + {5'd0, bus.fe_address};
          if (burst_q != BURST_LIMIT) burst_d = burst_q + 8'd1;
        end
      end
      DE_OWN: begin
        if (!bus.de_req || (burst_q == BURST_LIMIT && bus.fe_req)) begin
          state_d = bus.fe_req ? FE_OWN : IDLE;
          burst_d = 8'd0;
          rr_d    = 1'b0;
        end else begin
          de_gnt = 1'b1;
          addr_d = DE_BASE + {1'b0, bus.de_address};
          if (burst_q != BURST_LIMIT) burst_d = burst_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      burst_q   <= 8'd0;
      addr_q    <= 21'd0;
      iss_q     <= '0;
      own_q     <= '0;
      fe_data_q <= 8'd0;
      de_data_q <= 8'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      iss_q   <= iss_chain[RD_LAT-1:0];
      own_q   <= own_chain[RD_LAT-1:0];
      if (iss_chain[RD_LAT-1]) begin
        if (own_chain[RD_LAT-1]) de_data_q <= bus.fram_datain;
        else                     fe_data_q <= bus.fram_datain;
      end
    end
  end

  assign bus.fe_grant     = fe_gnt;
  assign bus.de_grant     = de_gnt;
  assign bus.fram_address = addr_q;
  assign bus.fe_valid     = iss_chain[RD_LAT] & ~own_chain[RD_LAT];
  assign bus.de_valid     = iss_chain[RD_LAT] &  own_chain[RD_LAT];
  assign bus.fe_data      = fe_data_q;
  assign bus.de_data      = de_data_q;
  assign bus.busy         = (state_q != IDLE) | (|iss_chain[RD_LAT:1]);

`ifdef FRAM_ARB_STATS_EN
  logic [15:0] fe_cnt_q, de_cnt_q, stall_cnt_q;
  logic        stall;

  // A cycle stalls when any requester is asking and is not being granted.
  assign stall = (bus.fe_req & ~fe_gnt) | (bus.de_req & ~de_gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe_cnt_q    <= 16'd0;
      de_cnt_q    <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else if (stats_clr) begin
      fe_cnt_q    <= 16'd0;
      de_cnt_q    <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (fe_gnt && !(&fe_cnt_q))      fe_cnt_q    <= fe_cnt_q + 16'd1;
      if (de_gnt && !(&de_cnt_q))      de_cnt_q    <= de_cnt_q + 16'd1;
      if (stall  && !(&stall_cnt_q))   stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fe_cnt    = fe_cnt_q;
  assign de_cnt    = de_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fram_arbiter
// Description : Directed self-checking bench for fram_arbiter with
//               RD_LAT=2, MAX_BURST=8, FE_BASE=21'h100000,
//               DE_BASE=21'h1FFFF0 (nonzero so de address wrap is visible).
//               Memory is modelled as a combinational function of
//               fram_address, so with RD_LAT=2 a grant in cycle G returns
//               data in cycle G+2.
//               Build with FRAM_ARB_STATS_EN to also exercise the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fram_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fram_arbiter_if bus ();

`ifdef FRAM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] fe_cnt, de_cnt, stall_cnt;
`endif

  fram_arbiter #(
    .RD_LAT    (2),
    .MAX_BURST (8),
    .FE_BASE   (21'h100000),
    .DE_BASE   (21'h1FFFF0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef FRAM_ARB_STATS_EN
    .stats_clr (stats_clr),
    .fe_cnt    (fe_cnt),
    .de_cnt    (de_cnt),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  function automatic logic [7:0] mem_byte(input logic [20:0] a);
    return a[7:0] ^ {a[12:8], a[20:18]} ^ 8'h5A;
  endfunction

  assign bus.fram_datain = mem_byte(bus.fram_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.fe_req = 1'b0;
    bus.de_req = 1'b0;
    #1;
    reset      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.fe_req     = 1'b0;
    bus.de_req     = 1'b0;
    bus.fe_address = 16'd0;
    bus.de_address = 20'd0;
`ifdef FRAM_ARB_STATS_EN
    stats_clr      = 1'b0;
`endif
    #2;
    // ---------------- reset state
    check_eq("rst_fe_grant", bus.fe_grant, 0);
    check_eq("rst_de_grant", bus.de_grant, 0);
    check_eq("rst_fe_valid", bus.fe_valid, 0);
    check_eq("rst_de_valid", bus.de_valid, 0);
    check_eq("rst_busy",     bus.busy, 0);
    check_eq("rst_addr",     bus.fram_address, 0);
    check_eq("rst_fe_data",  bus.fe_data, 0);
    check_eq("rst_de_data",  bus.de_data, 0);

    // ---------------- single fe burst of 3 reads at 0x0005
    step(); reset = 1'b0; bus.fe_req = 1'b1; bus.fe_address = 16'h0005; #2;
    check_eq("t1_c0_fe_grant", bus.fe_grant, 0);
    step(); #2;
    check_eq("t1_c1_fe_grant", bus.fe_grant, 1);
    check_eq("t1_c1_busy",     bus.busy, 1);
    step(); #2;
    check_eq("t1_c2_fe_grant", bus.fe_grant, 1);
    check_eq("t1_c2_addr",     bus.fram_address, 21'h100005);
    check_eq("t1_c2_fe_valid", bus.fe_valid, 0);
    step(); #2;
    check_eq("t1_c3_fe_grant", bus.fe_grant, 1);
    check_eq("t1_c3_fe_valid", bus.fe_valid, 1);
    check_eq("t1_c3_fe_data",  bus.fe_data, mem_byte(21'h100005));
    check_eq("t1_c3_de_valid", bus.de_valid, 0);
    step(); bus.fe_req = 1'b0; #2;
    check_eq("t1_c4_fe_grant", bus.fe_grant, 0);
    check_eq("t1_c4_fe_valid", bus.fe_valid, 1);
    step(); #2;
    check_eq("t1_c5_fe_valid", bus.fe_valid, 1);
    check_eq("t1_c5_busy",     bus.busy, 1);
    check_eq("t1_c5_de_valid", bus.de_valid, 0);
    step(); #2;
    check_eq("t1_c6_fe_valid", bus.fe_valid, 0);
    check_eq("t1_c6_busy",     bus.busy, 0);

    // ---------------- simultaneous requests, rr starts at fe, de wraps
    step(); do_reset();
    step();
    bus.fe_req = 1'b1; bus.fe_address = 16'h0010;
    bus.de_req = 1'b1; bus.de_address = 20'h00020; #2;
    check_eq("t2_c0_grants", {bus.fe_grant, bus.de_grant}, 2'b00);
    step(); #2;
    check_eq("t2_c1_grants", {bus.fe_grant, bus.de_grant}, 2'b10);
    step(); bus.fe_address = 16'h0011; #2;
    check_eq("t2_c2_grants", {bus.fe_grant, bus.de_grant}, 2'b10);
    step(); bus.fe_req = 1'b0; #2;
    check_eq("t2_c3_grants",   {bus.fe_grant, bus.de_grant}, 2'b00);
    check_eq("t2_c3_addr",     bus.fram_address, 21'h100011);
    check_eq("t2_c3_fe_valid", bus.fe_valid, 1);
    check_eq("t2_c3_fe_data",  bus.fe_data, mem_byte(21'h100010));
    step(); #2;
    check_eq("t2_c4_grants",   {bus.fe_grant, bus.de_grant}, 2'b01);
    check_eq("t2_c4_fe_data",  bus.fe_data, mem_byte(21'h100011));
    step(); bus.de_address = 20'hFFFFF; #2;
    check_eq("t2_c5_grants",   {bus.fe_grant, bus.de_grant}, 2'b01);
    check_eq("t2_c5_addr_wrap", bus.fram_address, 21'h000010);
    check_eq("t2_c5_fe_valid", bus.fe_valid, 0);
    step(); bus.de_req = 1'b0; #2;
    check_eq("t2_c6_de_grant", bus.de_grant, 0);
    check_eq("t2_c6_addr_wrap", bus.fram_address, 21'h0FFFEF);
    check_eq("t2_c6_de_valid", bus.de_valid, 1);
    check_eq("t2_c6_de_data",  bus.de_data, mem_byte(21'h000010));
    step(); #2;
    check_eq("t2_c7_de_valid", bus.de_valid, 1);
    check_eq("t2_c7_de_data",  bus.de_data, mem_byte(21'h0FFFEF));
    check_eq("t2_c7_fe_data_hold", bus.fe_data, mem_byte(21'h100011));
    check_eq("t2_c7_fe_valid", bus.fe_valid, 0);

    // ---------------- both held: 8 fe, gap, 8 de, gap, ...
    step(); do_reset();
    step();
    bus.fe_req = 1'b1; bus.fe_address = 16'h0030;
    bus.de_req = 1'b1; bus.de_address = 20'h00040;
    for (int k = 0; k < 40; k++) begin
      logic [1:0] exp_g;
      if (k != 0) step();
      #2;
      if (k == 0) exp_g = 2'b00;
      else if (((k - 1) % 9) == 8) exp_g = 2'b00;
      else if ((((k - 1) / 9) % 2) == 0) exp_g = 2'b10;
      else exp_g = 2'b01;
      check_eq($sformatf("t3_k%0d_grants", k),
               {bus.fe_grant, bus.de_grant}, exp_g);
    end
    step(); bus.fe_req = 1'b0; bus.de_req = 1'b0;
    repeat (4) step();

    // ---------------- lone fe saturates, then de forces a handover
    step(); do_reset();
    step(); bus.fe_req = 1'b1; bus.fe_address = 16'h0007; #2;
    check_eq("t4_c0_fe_grant", bus.fe_grant, 0);
    for (int i = 0; i < 12; i++) begin
      step(); #2;
      check_eq($sformatf("t4_sat%0d_fe_grant", i), bus.fe_grant, 1);
    end
    step(); bus.de_req = 1'b1; bus.de_address = 20'h00001; #2;
    check_eq("t4_handover_grants", {bus.fe_grant, bus.de_grant}, 2'b00);
    step(); #2;
    check_eq("t4_de_first_grants", {bus.fe_grant, bus.de_grant}, 2'b01);
    step(); bus.fe_req = 1'b0; bus.de_req = 1'b0;
    repeat (4) step();

    // ---------------- reset with two reads in flight
    step(); do_reset();
    step(); bus.fe_req = 1'b1; bus.fe_address = 16'h0009; #2;
    step(); #2;
    check_eq("t5_c1_fe_grant", bus.fe_grant, 1);
    step(); #2;
    check_eq("t5_c2_fe_grant", bus.fe_grant, 1);
    step(); reset = 1'b1; #2;
    check_eq("t5_rst_fe_valid", bus.fe_valid, 0);
    check_eq("t5_rst_busy",     bus.busy, 0);
    check_eq("t5_rst_addr",     bus.fram_address, 0);
    check_eq("t5_rst_fe_data",  bus.fe_data, 0);
    check_eq("t5_rst_fe_grant", bus.fe_grant, 0);
    bus.fe_req = 1'b0;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); #2;
      check_eq($sformatf("t5_post%0d_valids", i),
               {bus.fe_valid, bus.de_valid}, 2'b00);
    end

`ifdef FRAM_ARB_STATS_EN
    // ---------------- statistics: 5 fe grants, 3 de grants, 4 stalls
    step(); do_reset();
    step(); bus.fe_req = 1'b1; #2;                  // stall (IDLE)
    for (int i = 0; i < 4; i++) step();             // fe grants 1..4
    step(); bus.de_req = 1'b1; #2;                  // fe grant 5, de stalls
    step(); bus.fe_req = 1'b0; #2;                  // fe release, de stalls
    step(); step(); step();                         // de grants 1..3
    step(); bus.de_req = 1'b0; bus.fe_req = 1'b1; #2; // fe stalls
    step(); bus.fe_req = 1'b0; #2;                  // fe owns, releases
    step(); #2;
    check_eq("st_fe_cnt",    fe_cnt, 5);
    check_eq("st_de_cnt",    de_cnt, 3);
    check_eq("st_stall_cnt", stall_cnt, 4);
    stats_clr = 1'b1;
    step(); stats_clr = 1'b0; #2;
    check_eq("st_clr_fe_cnt",    fe_cnt, 0);
    check_eq("st_clr_de_cnt",    de_cnt, 0);
    check_eq("st_clr_stall_cnt", stall_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
